pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
Central hazard and sequencing controller for the 5-stage rv32i pipeline.
- Drives the enable/flush pins of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use/RAW hazards, taken-branch redirects, instruction-fetch wait and data-memory wait.
- Tracks a stale in-flight fetch after a redirect.
- Exposes saturating stall and flush performance counters.

Parameters:
FORWARDING, 1, 1 = EX/MEM forwarding present (only load-use stalls); 0 = any RAW against EX or MEM stalls.
CNT_W, 32, width of performance counters.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination reg in EX
ex_reg_write  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
mem_rd  in  5  destination reg in MEM
mem_reg_write  in  1  MEM instruction writes rd
ex_branch_taken  in  1  EX resolved taken branch/jump
ex_branch_target  in  32  redirect PC
imem_ready  in  1  fetch data valid this cycle
mem_dmem_req  in  1  MEM stage has an active data access
dmem_ready  in  1  data access completes this cycle
pc_enable  out  1  PC register load
pc_redirect  out  1  PC mux selects pc_redirect_target
pc_redirect_target  out  32  = ex_branch_target (pass-through)
ifid_enable / ifid_flush  out  1 / 1  IF/ID load / load NOP
idex_enable / idex_flush  out  1 / 1  ID/EX load / load NOP
exmem_enable  out  1  EX/MEM load
memwb_enable  out  1  MEM/WB load
stall_count  out  CNT_W  cycles with pc_enable=0
flush_count  out  CNT_W  taken redirects

Behaviour:
- Reset: rst synchronous active-high. While rst=1:
  - state<=RUN; counters<=0.
  - Outputs: pc_enable=0, pc_redirect=0, ifid_enable=1, ifid_flush=1, idex_enable=1, idex_flush=1, exmem_enable=0, memwb_enable=0.
  - Applies mid-operation; a pending DROP is discarded.
- Invariant: flush=1 implies the matching enable=1.
- Control outputs are combinational from state and inputs; zero latency.
- State machine:
  - RUN: normal operation.
  - DROP: one stale fetch is outstanding and must be discarded.
- Hazard definitions (register 0 never hazards):
  - match_ex = ex_reg_write and ex_rd!=0 and ex_rd equals a used ID source.
  - match_mem is the same check against mem_rd/mem_reg_write.
  - FORWARDING=1: hazard = match_ex and ex_is_load.
  - FORWARDING=0: hazard = match_ex or match_mem.
  - WB produces no hazard; the register file bypasses writes.
- Per-cycle priority, RUN and DROP both, first match wins:
  1. dmem_wait (mem_dmem_req and not dmem_ready): every enable 0, every flush 0. A simultaneous branch or hazard stays frozen and is re-evaluated next cycle.
  2. ex_branch_taken: pc_enable=1, pc_redirect=1, ifid_flush=1, idex_flush=1, exmem/memwb enable 1. If imem_ready=0, next state DROP; else next state RUN. flush_count++.
  3. DROP: pc_enable=0, ifid_flush=1, idex/exmem/memwb enable 1. When imem_ready=1 the returning word is discarded and next state is RUN.
  4. hazard: pc_enable=0, ifid_enable=0, idex_flush=1 (bubble), exmem/memwb enable 1.
  5. imem wait (imem_ready=0): pc_enable=0, ifid_flush=1, idex/exmem/memwb enable 1.
  6. Otherwise all enables 1, all flushes 0.
- DROP during dmem_wait: if imem_ready=1 in that cycle, the stale word is still consumed and DROP exits to RUN.
- pc_redirect=0 whenever rule 2 is not active.
- Counters:
  - stall_count increments when pc_enable=0 and rst=0.
  - Both counters saturate at all-ones.

Decomposition:
- Shared package pipe_pkg: ctrl_state_t enum {RUN, DROP}; REG_ZERO=5'd0; pipe_ctrl_t struct bundling the enable/flush fields.
- One sub-module: sat_counter (CNT_W, inc) instantiated twice for the counters.

Test Plan:
- Reset: rst=1 two cycles, then 0 with imem_ready=1 and no hazards -> during reset ifid_flush=idex_flush=1 and pc_enable=0; after, all enables 1, counters 0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, FORWARDING=1 -> one cycle pc_enable=0, ifid_enable=0, idex_flush=1; stall_count=1. Same with ex_rd=0 -> no stall.
- RAW without forwarding: FORWARDING=0, mem_rd=7, mem_reg_write=1, id_rs2=7 -> stall asserted. FORWARDING=1 -> no stall.
- Branch with fetch ready: ex_branch_taken=1, target 0x0000_0100, imem_ready=1 -> pc_redirect=1, target 0x100, both flushes 1, flush_count=1, state stays RUN.
- Branch during fetch wait: branch with imem_ready=0, then imem_ready low 2 cycles, then high -> DROP for 3 cycles with ifid_flush=1 and pc_enable=0; RUN on the imem_ready cycle; stall_count=3.
- dmem stall vs branch: mem_dmem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 -> all enables 0 for 3 cycles, no redirect; on the fourth cycle dmem_ready=1 -> redirect issued once, flush_count=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the rv32i pipeline hazard/sequencing controller.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DROP = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_enable;
    logic ifid_enable;
    logic ifid_flush;
    logic idex_enable;
    logic idex_flush;
    logic exmem_enable;
    logic memwb_enable;
  } pipe_ctrl_t;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_hit(
    input logic [4:0] rd,
    input logic       rd_write,
    input logic [4:0] rs1,
    input logic       uses_rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return rd_write && (rd != REG_ZERO) &&
           ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the 5-stage rv32i pipeline.
//   state | meaning
//   RUN   | normal operation
//   DROP  | a stale fetch from before a redirect is still outstanding
module pipeline_control
  import pipe_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             imem_ready,
  input  logic             mem_dmem_req,
  input  logic             dmem_ready,
  output logic             pc_enable,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_target,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             memwb_enable,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  pipe_ctrl_t  ctrl;
  logic        redirect;
  logic        match_ex;
  logic        match_mem;
  logic        hazard;
  logic        dmem_wait;

  always_comb begin
    match_ex  = reg_hit(ex_rd, ex_reg_write, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);
    match_mem = reg_hit(mem_rd, mem_reg_write, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2);
    if (FORWARDING != 0) begin
      hazard = match_ex && ex_is_load;
    end else begin
      hazard = match_ex || match_mem;
    end
    dmem_wait = mem_dmem_req && !dmem_ready;
  end

  always_comb begin
    ctrl     = '0;
    redirect = 1'b0;
    state_d  = state_q;
    if (rst) begin
      ctrl.ifid_enable = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_enable = 1'b1;
      ctrl.idex_flush  = 1'b1;
      state_d          = RUN;
    end else if (dmem_wait) begin
      // Whole pipe frozen, but a returning stale word is still swallowed.
      if ((state_q == DROP) && imem_ready) begin
        state_d = RUN;
      end
    end else if (ex_branch_taken) begin
      redirect          = 1'b1;
      ctrl.pc_enable    = 1'b1;
      ctrl.ifid_enable  = 1'b1;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idex_enable  = 1'b1;
      ctrl.idex_flush   = 1'b1;
      ctrl.exmem_enable = 1'b1;
      ctrl.memwb_enable = 1'b1;
      state_d           = imem_ready ? RUN : DROP;
    end else if (state_q == DROP) begin
      ctrl.ifid_enable  = 1'b1;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idex_enable  = 1'b1;
      ctrl.exmem_enable = 1'b1;
      ctrl.memwb_enable = 1'b1;
      if (imem_ready) begin
        state_d = RUN;
      end
    end else if (hazard) begin
      ctrl.idex_enable  = 1'b1;
      ctrl.idex_flush   = 1'b1;
      ctrl.exmem_enable = 1'b1;
      ctrl.memwb_enable = 1'b1;
    end else if (!imem_ready) begin
      ctrl.ifid_enable  = 1'b1;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idex_enable  = 1'b1;
      ctrl.exmem_enable = 1'b1;
      ctrl.memwb_enable = 1'b1;
    end else begin
      ctrl.pc_enable    = 1'b1;
      ctrl.ifid_enable  = 1'b1;
      ctrl.idex_enable  = 1'b1;
      ctrl.exmem_enable = 1'b1;
      ctrl.memwb_enable = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_enable          = ctrl.pc_enable;
  assign pc_redirect        = redirect;
  assign pc_redirect_target = ex_branch_target;
  assign ifid_enable        = ctrl.ifid_enable;
  assign ifid_flush         = ctrl.ifid_flush;
  assign idex_enable        = ctrl.idex_enable;
  assign idex_flush         = ctrl.idex_flush;
  assign exmem_enable       = ctrl.exmem_enable;
  assign memwb_enable       = ctrl.memwb_enable;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctrl.pc_enable),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: forwarding and non-forwarding instances plus a narrow-counter instance.
module tb_pipeline_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load, mem_reg_write;
  logic        ex_branch_taken, imem_ready, mem_dmem_req, dmem_ready;
  logic [31:0] ex_branch_target;

  logic        pc_en_a, red_a, ifid_en_a, ifid_fl_a, idex_en_a, idex_fl_a, exmem_a, memwb_a;
  logic [31:0] tgt_a, stall_a, flush_a;
  logic        pc_en_b, red_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_b, memwb_b;
  logic [31:0] tgt_b, stall_b, flush_b;
  logic        pc_en_c, red_c, ifid_en_c, ifid_fl_c, idex_en_c, idex_fl_c, exmem_c, memwb_c;
  logic [31:0] tgt_c;
  logic [1:0]  stall_c, flush_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_control #(.FORWARDING(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .imem_ready(imem_ready), .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
    .pc_enable(pc_en_a), .pc_redirect(red_a), .pc_redirect_target(tgt_a),
    .ifid_enable(ifid_en_a), .ifid_flush(ifid_fl_a),
    .idex_enable(idex_en_a), .idex_flush(idex_fl_a),
    .exmem_enable(exmem_a), .memwb_enable(memwb_a),
    .stall_count(stall_a), .flush_count(flush_a)
  );

  pipeline_control #(.FORWARDING(0), .CNT_W(32)) u_dut_nf (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .imem_ready(imem_ready), .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
    .pc_enable(pc_en_b), .pc_redirect(red_b), .pc_redirect_target(tgt_b),
    .ifid_enable(ifid_en_b), .ifid_flush(ifid_fl_b),
    .idex_enable(idex_en_b), .idex_flush(idex_fl_b),
    .exmem_enable(exmem_b), .memwb_enable(memwb_b),
    .stall_count(stall_b), .flush_count(flush_b)
  );

  pipeline_control #(.FORWARDING(1), .CNT_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .imem_ready(imem_ready), .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready),
    .pc_enable(pc_en_c), .pc_redirect(red_c), .pc_redirect_target(tgt_c),
    .ifid_enable(ifid_en_c), .ifid_flush(ifid_fl_c),
    .idex_enable(idex_en_c), .idex_flush(idex_fl_c),
    .exmem_enable(exmem_c), .memwb_enable(memwb_c),
    .stall_count(stall_c), .flush_count(flush_c)
  );

  // {pc_enable, pc_redirect, ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable, memwb_enable}
  wire [7:0] ctrl_a = {pc_en_a, red_a, ifid_en_a, ifid_fl_a, idex_en_a, idex_fl_a, exmem_a, memwb_a};
  wire [7:0] ctrl_b = {pc_en_b, red_b, ifid_en_b, ifid_fl_b, idex_en_b, idex_fl_b, exmem_b, memwb_b};
  wire [7:0] ctrl_c = {pc_en_c, red_c, ifid_en_c, ifid_fl_c, idex_en_c, idex_fl_c, exmem_c, memwb_c};

  localparam logic [7:0] C_RESET  = 8'b0011_1100;
  localparam logic [7:0] C_RUN    = 8'b1010_1011;
  localparam logic [7:0] C_BUBBLE = 8'b0000_1111;
  localparam logic [7:0] C_BRANCH = 8'b1111_1111;
  localparam logic [7:0] C_FETCHW = 8'b0011_1011;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    imem_ready = 1'b1; mem_dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("reset_ctrl", ctrl_a, C_RESET);
    tick();
    chk("reset_ctrl_2", ctrl_a, C_RESET);
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset_ctrl", ctrl_a, C_RUN);
    chk("post_reset_stall", stall_a, 0);
    chk("post_reset_flush", flush_a, 0);
    tick();

    // load-use on rs1
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    chk("loaduse_fwd", ctrl_a, C_BUBBLE);
    chk("loaduse_nofwd", ctrl_b, C_BUBBLE);
    tick();
    chk("loaduse_stall_cnt", stall_a, 1);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    chk("loaduse_x0_fwd", ctrl_a, C_RUN);
    chk("loaduse_x0_nofwd", ctrl_b, C_RUN);
    tick();
    chk("loaduse_x0_stall_cnt", stall_a, 1);

    // ALU result in EX: forwarded vs stalled
    ex_is_load = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    chk("alu_ex_fwd", ctrl_a, C_RUN);
    chk("alu_ex_nofwd", ctrl_b, C_BUBBLE);
    tick();

    // RAW against MEM on rs2
    idle_inputs();
    mem_rd = 5'd7; mem_reg_write = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1;
    chk("raw_mem_fwd", ctrl_a, C_RUN);
    chk("raw_mem_nofwd", ctrl_b, C_BUBBLE);
    id_uses_rs2 = 1'b0;
    #1;
    chk("raw_mem_unused_nofwd", ctrl_b, C_RUN);
    tick();

    // taken branch, fetch ready
    do_reset();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0100;
    #1;
    chk("branch_ctrl", ctrl_a, C_BRANCH);
    chk("branch_target", tgt_a, 32'h0000_0100);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    chk("branch_after_run", ctrl_a, C_RUN);
    chk("branch_flush_cnt", flush_a, 1);
    chk("branch_stall_cnt", stall_a, 0);

    // taken branch during fetch wait -> DROP
    do_reset();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0200; imem_ready = 1'b0;
    #1;
    chk("brwait_ctrl", ctrl_a, C_BRANCH);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    chk("drop_1", ctrl_a, C_FETCHW);
    tick();
    // load-use hazard is masked by DROP
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1;
    chk("drop_2_hazard", ctrl_a, C_FETCHW);
    tick();
    ex_is_load = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("drop_3_consume", ctrl_a, C_FETCHW);
    tick();
    chk("drop_exit_run", ctrl_a, C_RUN);
    chk("drop_stall_cnt", stall_a, 3);
    chk("drop_flush_cnt", flush_a, 1);
    chk("drop_small_stall", stall_c, 3);
    chk("drop_small_flush", flush_c, 1);

    // counter saturation on the 2-bit instance
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_wide_stall", stall_a, 5);
    chk("sat_small_stall", stall_c, 2'b11);
    imem_ready = 1'b1;

    // dmem wait freezes a pending branch
    do_reset();
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dmem_freeze", ctrl_a, C_FREEZE);
      tick();
    end
    chk("dmem_freeze_flush_cnt", flush_a, 0);
    chk("dmem_freeze_stall_cnt", stall_a, 3);
    dmem_ready = 1'b1;
    #1;
    chk("dmem_release_branch", ctrl_a, C_BRANCH);
    tick();
    ex_branch_taken = 1'b0; mem_dmem_req = 1'b0;
    #1;
    chk("dmem_release_flush_cnt", flush_a, 1);
    chk("dmem_release_run", ctrl_a, C_RUN);

    // DROP consumes its stale word even while data memory stalls
    do_reset();
    ex_branch_taken = 1'b1; imem_ready = 1'b0;
    tick();
    ex_branch_taken = 1'b0; imem_ready = 1'b1; mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("drop_dmem_freeze", ctrl_a, C_FREEZE);
    tick();
    mem_dmem_req = 1'b0;
    #1;
    chk("drop_dmem_exit_run", ctrl_a, C_RUN);

    // reset mid-DROP discards it
    do_reset();
    ex_branch_taken = 1'b1; imem_ready = 1'b0;
    tick();
    ex_branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_drop_ctrl", ctrl_a, C_RESET);
    tick();
    rst = 1'b0; imem_ready = 1'b1;
    #1;
    chk("rst_in_drop_run", ctrl_a, C_RUN);
    chk("rst_in_drop_flush_cnt", flush_a, 0);
    chk("rst_in_drop_stall_cnt", stall_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
